// File: rtl/multicycle_control_unit_if.sv
// Memory handshake bundle between the multi-cycle control unit and the
// instruction/data memories: imem_req/imem_ready, dmem_req/dmem_ready.
interface multicycle_control_unit_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT.
// Ports: clk, rst (sync, active-high); mem (imem/dmem req/ready master);
// opcode (IR field); datapath controls ir_write, pc_write, alu_op, alu_src,
// branch, jump, mem_read, mem_write, mem_2_reg, reg_write; status
// instr_done, mem_error, halted, instr_count.
// Optional macro ILLEGAL_TRAP_EN: unknown opcode halts instead of NOP.
module multicycle_control_unit #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    multicycle_control_unit_if.master mem,
    input  logic [6:0]                opcode,
    output logic                      ir_write,
    output logic                      pc_write,
    output logic [1:0]                alu_op,
    output logic                      alu_src,
    output logic                      branch,
    output logic                      jump,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic                      mem_2_reg,
    output logic                      reg_write,
    output logic                      instr_done,
    output logic                      mem_error,
    output logic                      halted,
    output logic [CNT_W-1:0]          instr_count
);

    localparam logic [6:0] OP_ALU_R = 7'b0110011;
    localparam logic [6:0] OP_ALU_I = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;

    localparam bit TO_EN = (MEM_TIMEOUT != 0);
    // Last wait count before the limit: one more unanswered cycle times out.
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'(TO_EN ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        op_q, op_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    logic              err_set;
    logic              imem_req_c;
    logic              dmem_req_c;
    logic              known_op;
    logic              to_hit;

    always_comb begin
        case (opcode)
            OP_ALU_R, OP_ALU_I, OP_BEQ,
            OP_JAL, OP_LW, OP_SW: known_op = 1'b1;
            default:              known_op = 1'b0;
        endcase
    end

    assign to_hit = TO_EN && (to_q == TO_LAST);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        to_d       = '0;
        err_set    = 1'b0;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        alu_op     = 2'b00;
        alu_src    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_2_reg  = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (mem.imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (to_hit) begin
                    err_set = 1'b1;
                    state_d = S_HALT;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (known_op) begin
                    state_d = S_EXECUTE;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
`endif
                end
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                case (op_q)
                    OP_ALU_R: begin
                        alu_op  = 2'b10;
                        state_d = S_WRITEBACK;
                    end
                    OP_ALU_I: begin
                        alu_src = 1'b1;
                        state_d = S_WRITEBACK;
                    end
                    OP_BEQ: begin
                        alu_op     = 2'b01;
                        branch     = 1'b1;
                        instr_done = 1'b1;
                    end
                    OP_JAL: begin
                        jump       = 1'b1;
                        instr_done = 1'b1;
                    end
                    OP_LW, OP_SW: begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                mem_read   = (op_q == OP_LW);
                mem_write  = (op_q == OP_SW);
                if (mem.dmem_ready) begin
                    if (op_q == OP_LW) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end else if (to_hit) begin
                    err_set = 1'b1;
                    state_d = S_HALT;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_WRITEBACK: begin
                reg_write  = 1'b1;
                mem_2_reg  = (op_q == OP_LW);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset silences every output whatever the state register holds.
        if (rst) begin
            imem_req_c = 1'b0;
            dmem_req_c = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            alu_op     = 2'b00;
            alu_src    = 1'b0;
            branch     = 1'b0;
            jump       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            mem_2_reg  = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
            halted     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            to_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            to_q    <= to_d;
            if (instr_done) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mem.imem_req = imem_req_c;
    assign mem.dmem_req = dmem_req_c;
    assign mem_error    = ~rst & err_q;
    assign instr_count  = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: instruction-level expected-cycle model
// driven by directed instruction vectors, checked every cycle.
module tb_multicycle_control_unit;

    localparam int TO = 16;

    localparam logic [6:0] OPR = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] OPB = 7'b1100011;
    localparam logic [6:0] OPJ = 7'b1101111;
    localparam logic [6:0] OPL = 7'b0000011;
    localparam logic [6:0] OPS = 7'b0100011;
    localparam logic [6:0] OPX = 7'b1111111;

    localparam logic [15:0] O_IREQ = 16'h8000;
    localparam logic [15:0] O_DREQ = 16'h4000;
    localparam logic [15:0] O_IRW  = 16'h2000;
    localparam logic [15:0] O_PCW  = 16'h1000;
    localparam logic [15:0] O_ALUR = 16'h0800;
    localparam logic [15:0] O_SUB  = 16'h0400;
    localparam logic [15:0] O_SRC  = 16'h0200;
    localparam logic [15:0] O_BR   = 16'h0100;
    localparam logic [15:0] O_JMP  = 16'h0080;
    localparam logic [15:0] O_RD   = 16'h0040;
    localparam logic [15:0] O_WR   = 16'h0020;
    localparam logic [15:0] O_M2R  = 16'h0010;
    localparam logic [15:0] O_RW   = 16'h0008;
    localparam logic [15:0] O_DONE = 16'h0004;
    localparam logic [15:0] O_ERR  = 16'h0002;
    localparam logic [15:0] O_HLT  = 16'h0001;

    logic        clk = 1'b1;
    logic        rst;
    logic [6:0]  opcode;
    logic        ir_write, pc_write, alu_src, branch, jump;
    logic        mem_read, mem_write, mem_2_reg, reg_write;
    logic        instr_done, mem_error, halted;
    logic [1:0]  alu_op;
    logic [31:0] instr_count;
    logic [15:0] got;

    multicycle_control_unit_if bus();

    multicycle_control_unit #(
        .CNT_W(32), .MEM_TIMEOUT(TO), .TO_W(5)
    ) dut (
        .clk(clk), .rst(rst), .mem(bus), .opcode(opcode),
        .ir_write(ir_write), .pc_write(pc_write), .alu_op(alu_op),
        .alu_src(alu_src), .branch(branch), .jump(jump),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_2_reg(mem_2_reg), .reg_write(reg_write),
        .instr_done(instr_done), .mem_error(mem_error),
        .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign got = {bus.imem_req, bus.dmem_req, ir_write, pc_write, alu_op,
                  alu_src, branch, jump, mem_read, mem_write, mem_2_reg,
                  reg_write, instr_done, mem_error, halted};

    typedef struct packed {
        logic        rst;
        logic        ir;
        logic        dr;
        logic [6:0]  op;
        logic [15:0] outs;
        logic [31:0] cnt;
    } cyc_t;

    cyc_t q[$];
    cyc_t cur;
    bit   cur_valid = 1'b0;
    int   row = 0;
    int   total = 0;
    int   bad = 0;
    int   model_cnt = 0;
    bit   model_err = 1'b0;

    task automatic push(input logic r, input logic ir, input logic dr,
                        input logic [6:0] op, input logic [15:0] o);
        cyc_t e;
        e.rst = r;
        e.ir  = ir;
        e.dr  = dr;
        e.op  = op;
        if (r) begin
            e.outs    = '0;
            e.cnt     = '0;
            model_cnt = 0;
            model_err = 1'b0;
        end else begin
            e.outs = o | (model_err ? O_ERR : 16'h0);
            e.cnt  = 32'(model_cnt);
            if ((o & O_DONE) != 16'h0) model_cnt++;
        end
        q.push_back(e);
    endtask

    task automatic halt_rows(input logic [6:0] op);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 1'b1, op, O_HLT);
    endtask

    task automatic do_reset();
        push(1'b1, 1'b0, 1'b0, 7'd0, 16'h0);
        push(1'b1, 1'b0, 1'b0, 7'd0, 16'h0);
    endtask

    task automatic mem_phase(input logic [6:0] op, input int dw);
        logic [15:0] rw;
        rw = (op == OPL) ? O_RD : O_WR;
        if (dw >= TO) begin
            for (int i = 0; i < TO; i++) push(1'b0, 1'b1, 1'b0, op, O_DREQ | rw);
            model_err = 1'b1;
            halt_rows(op);
        end else begin
            for (int i = 0; i < dw; i++) push(1'b0, 1'b1, 1'b0, op, O_DREQ | rw);
            push(1'b0, 1'b1, 1'b1, op,
                 O_DREQ | rw | ((op == OPS) ? O_DONE : 16'h0));
            if (op == OPL) push(1'b0, 1'b1, 1'b1, op, O_RW | O_M2R | O_DONE);
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input int iw, input int dw);
        if (iw >= TO) begin
            for (int i = 0; i < TO; i++) push(1'b0, 1'b0, 1'b1, op, O_IREQ);
            model_err = 1'b1;
            halt_rows(op);
        end else begin
            for (int i = 0; i < iw; i++) push(1'b0, 1'b0, 1'b1, op, O_IREQ);
            push(1'b0, 1'b1, 1'b1, op, O_IREQ | O_IRW | O_PCW);
            case (op)
                OPR: begin
                    push(1'b0, 1'b1, 1'b1, op, 16'h0);
                    push(1'b0, 1'b1, 1'b1, op, O_ALUR);
                    push(1'b0, 1'b1, 1'b1, op, O_RW | O_DONE);
                end
                OPI: begin
                    push(1'b0, 1'b1, 1'b1, op, 16'h0);
                    push(1'b0, 1'b1, 1'b1, op, O_SRC);
                    push(1'b0, 1'b1, 1'b1, op, O_RW | O_DONE);
                end
                OPB: begin
                    push(1'b0, 1'b1, 1'b1, op, 16'h0);
                    push(1'b0, 1'b1, 1'b1, op, O_SUB | O_BR | O_DONE);
                end
                OPJ: begin
                    push(1'b0, 1'b1, 1'b1, op, 16'h0);
                    push(1'b0, 1'b1, 1'b1, op, O_JMP | O_DONE);
                end
                OPL, OPS: begin
                    push(1'b0, 1'b1, 1'b1, op, 16'h0);
                    push(1'b0, 1'b1, 1'b1, op, O_SRC);
                    mem_phase(op, dw);
                end
                default: begin
`ifdef ILLEGAL_TRAP_EN
                    push(1'b0, 1'b1, 1'b1, op, 16'h0);
                    halt_rows(op);
`else
                    push(1'b0, 1'b1, 1'b1, op, O_DONE);
`endif
                end
            endcase
        end
    endtask

    task automatic play();
        while (q.size() > 0) begin
            cur            = q.pop_front();
            rst            = cur.rst;
            bus.imem_ready = cur.ir;
            bus.dmem_ready = cur.dr;
            opcode         = cur.op;
            cur_valid      = 1'b1;
            @(posedge clk);
            #1;
            row++;
        end
    endtask

    task automatic check(input string name, input logic [31:0] g,
                         input logic [31:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, g, e);
        end
    endtask

    always @(negedge clk) begin
        if (cur_valid) begin
            total++;
            if (got !== cur.outs) begin
                bad++;
                $display("FAIL outs row=%0d got=%h want=%h", row, got, cur.outs);
            end
            total++;
            if (instr_count !== cur.cnt) begin
                bad++;
                $display("FAIL count row=%0d got=%0d want=%0d",
                         row, instr_count, cur.cnt);
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        opcode         = 7'd0;

        do_reset();
        play();

        run_instr(OPR, 0, 0);
        check("lat_alu_r", 32'(q.size()), 32'd4);
        play();
        check("cnt_alu_r", instr_count, 32'd1);

        run_instr(OPL, 0, 3);
        check("lat_lw_wait3", 32'(q.size()), 32'd8);
        play();
        check("cnt_lw", instr_count, 32'd2);

        run_instr(OPB, 0, 0);
        run_instr(OPJ, 0, 0);
        check("lat_beq_jal", 32'(q.size()), 32'd6);
        play();
        check("cnt_beq_jal", instr_count, 32'd4);

        run_instr(OPI, 2, 0);
        run_instr(OPS, 1, 2);
        play();

        run_instr(OPR, 15, 0);
        run_instr(OPL, 0, 15);
        play();
        check("cnt_wait15", instr_count, 32'd8);
        check("err_wait15", mem_error, 32'd0);

        run_instr(OPX, 0, 0);
        play();
`ifdef ILLEGAL_TRAP_EN
        check("ill_halted", halted, 32'd1);
        check("ill_cnt", instr_count, 32'd8);
        do_reset();
        play();
`else
        check("ill_cnt", instr_count, 32'd9);
        check("ill_fetch", bus.imem_req, 32'd1);
`endif
        run_instr(OPJ, 0, 0);
        play();

        push(1'b0, 1'b1, 1'b1, OPS, O_IREQ | O_IRW | O_PCW);
        push(1'b0, 1'b1, 1'b1, OPS, 16'h0);
        push(1'b0, 1'b1, 1'b1, OPS, O_SRC);
        push(1'b0, 1'b1, 1'b0, OPS, O_DREQ | O_WR);
        push(1'b0, 1'b1, 1'b0, OPS, O_DREQ | O_WR);
        do_reset();
        run_instr(OPS, 0, 0);
        play();
        check("cnt_after_rst", instr_count, 32'd1);

        run_instr(OPR, 16, 0);
        play();
        check("ito_err", mem_error, 32'd1);
        check("ito_halt", halted, 32'd1);
        do_reset();
        run_instr(OPB, 0, 0);
        play();
        check("err_clr", mem_error, 32'd0);
        check("cnt_clr", instr_count, 32'd1);

        run_instr(OPS, 0, 20);
        play();
        check("dto_err", mem_error, 32'd1);
        do_reset();
        play();

        cur_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
